// File: rtl/systolic_feeder_pkg.sv
// Shared types and helpers for the systolic operand feeder and the MAC array manager.
//   state_e    : feeder run state
//   stream_len : beats per run for an NxN array (skew + zero flush)
//   lane_lsb   : bit offset of lane i in a packed [i*OP_WIDTH +: OP_WIDTH] bus
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Beats in one run: 2N-1 skewed operand beats plus N-1 flush beats.
  function automatic int unsigned stream_len(input int unsigned n);
    return 3 * n - 2;
  endfunction

  // Lane layout shared by every packed operand bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_feeder_operand_bank.sv
// NxN operand register file with one write port and N skewed read lanes.
//   clk        : clock
//   we_i       : write enable (row_i, col_i, data_i)
//   k_i        : beat index to read
//   lanes_c_o  : combinational read, lane l at [l*OP_WIDTH +: OP_WIDTH]
// Row mode    : lane l = M[l][k-l]; column mode: lane l = M[k-l][l]; 0 outside 0..N-1.
module systolic_feeder_operand_bank
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned OP_WIDTH = 8,
  parameter int unsigned IDX_W    = $clog2(N),
  parameter int unsigned CNT_W    = $clog2(3 * N),
  parameter bit          COL_MODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      row_i,
  input  logic [IDX_W-1:0]      col_i,
  input  logic [OP_WIDTH-1:0]   data_i,
  input  logic [CNT_W-1:0]      k_i,
  output logic [N*OP_WIDTH-1:0] lanes_c_o
);

  logic [OP_WIDTH-1:0] mem_q [N][N];
  logic                addr_ok;

  // Guards non-power-of-two N against writes past the last row/column.
  assign addr_ok = ({1'b0, row_i} < (IDX_W + 1)'(N)) && ({1'b0, col_i} < (IDX_W + 1)'(N));

  // Storage is intentionally not reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we_i && addr_ok) begin
      mem_q[row_i][col_i] <= data_i;
    end
  end

  // Skewed read: lane l lags the beat index by l, zero-padded on both ends.
  always_comb begin
    lanes_c_o = '0;
    for (int l = 0; l < int'(N); l++) begin
      if ((k_i >= CNT_W'(l)) && ((k_i - CNT_W'(l)) < CNT_W'(N))) begin
        if (COL_MODE) begin
          lanes_c_o[lane_lsb(l, OP_WIDTH) +: OP_WIDTH] = mem_q[IDX_W'(k_i - CNT_W'(l))][l];
        end else begin
          lanes_c_o[lane_lsb(l, OP_WIDTH) +: OP_WIDTH] = mem_q[l][IDX_W'(k_i - CNT_W'(l))];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand source for the systolic MAC array: buffers A and B, pulses an
// accumulator clear, then streams 3N-2 skewed beats (zero flush at the end).
//   clk, reset        : clock, async active-low reset
//   wr_en/sel/row/col/data : buffer write port (IDLE only; sel 0=A, 1=B)
//   start             : begin a run (IDLE only, not queued)
//   busy              : high from the clear cycle through the done cycle
//   acc_clear         : one-cycle accumulator clear
//   out_valid         : beat valid; buses are 0 when low
//   new_a_column      : A lane i = A[i][k-i]
//   new_b_row         : B lane j = B[k-j][j]
//   done              : one-cycle pulse after the last beat
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned OP_WIDTH = 8,
  parameter int unsigned IDX_W    = $clog2(N),
  parameter int unsigned CNT_W    = $clog2(3 * N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [IDX_W-1:0]      wr_row,
  input  logic [IDX_W-1:0]      wr_col,
  input  logic [OP_WIDTH-1:0]   wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  acc_clear,
  output logic                  out_valid,
  output logic [N*OP_WIDTH-1:0] new_a_column,
  output logic [N*OP_WIDTH-1:0] new_b_row,
  output logic                  done
);

  localparam int unsigned LAST_BEAT = stream_len(N) - 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(LAST_BEAT);

  state_e                state_q;
  logic [CNT_W-1:0]      k_q;
  logic                  busy_q;
  logic                  acc_clear_q;
  logic                  out_valid_q;
  logic                  done_q;
  logic [N*OP_WIDTH-1:0] a_q;
  logic [N*OP_WIDTH-1:0] b_q;

  logic                  we_a;
  logic                  we_b;
  logic [CNT_W-1:0]      rd_k;
  logic [N*OP_WIDTH-1:0] a_lanes;
  logic [N*OP_WIDTH-1:0] b_lanes;

  // Writes only land while idle, including the cycle start is sampled.
  assign we_a = wr_en && (state_q == IDLE) && !wr_sel;
  assign we_b = wr_en && (state_q == IDLE) &&  wr_sel;

  // Read one beat ahead so the registered bus shows beat k while k_q == k.
  assign rd_k = (state_q == STREAM) ? (k_q + CNT_W'(1)) : '0;

  systolic_feeder_operand_bank #(
    .N(N), .OP_WIDTH(OP_WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .COL_MODE(1'b0)
  ) u_bank_a (
    .clk      (clk),
    .we_i     (we_a),
    .row_i    (wr_row),
    .col_i    (wr_col),
    .data_i   (wr_data),
    .k_i      (rd_k),
    .lanes_c_o(a_lanes)
  );

  systolic_feeder_operand_bank #(
    .N(N), .OP_WIDTH(OP_WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .COL_MODE(1'b1)
  ) u_bank_b (
    .clk      (clk),
    .we_i     (we_b),
    .row_i    (wr_row),
    .col_i    (wr_col),
    .data_i   (wr_data),
    .k_i      (rd_k),
    .lanes_c_o(b_lanes)
  );

  // Run sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      busy_q      <= 1'b0;
      acc_clear_q <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= CLEAR;
            busy_q      <= 1'b1;
            acc_clear_q <= 1'b1;
            k_q         <= '0;
          end
        end
        CLEAR: begin
          state_q     <= STREAM;
          out_valid_q <= 1'b1;
          a_q         <= a_lanes;
          b_q         <= b_lanes;
          k_q         <= '0;
        end
        STREAM: begin
          if (k_q == LAST_K) begin
            state_q     <= DONE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
          end else begin
            k_q <= k_q + CNT_W'(1);
            a_q <= a_lanes;
            b_q <= b_lanes;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          k_q     <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign acc_clear    = acc_clear_q;
  assign out_valid    = out_valid_q;
  assign done         = done_q;
  assign new_a_column = a_q;
  assign new_b_row    = b_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: one N=2 and one N=4 instance, selected by cur_n.
// Expected beats come from the skew formula on a matrix model; MAC results
// come from a behavioural systolic accumulation over the captured beats.
module tb_systolic_feeder;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_sel, start;
  logic [1:0] wr_row, wr_col;
  logic [W-1:0] wr_data;
  int         cur_n;

  logic        busy2, acc2, valid2, done2;
  logic [15:0] a2, b2;
  logic        busy4, acc4, valid4, done4;
  logic [31:0] a4, b4;

  logic        sel4;
  logic        busy_o, acc_o, valid_o, done_o;
  logic [31:0] a_o, b_o;

  int n_checks = 0;
  int n_fail   = 0;

  int ma [4][4];
  int mb [4][4];
  logic [31:0] aq [$];
  logic [31:0] bq [$];

  always #5 clk = ~clk;

  assign sel4    = (cur_n == 4);
  assign busy_o  = sel4 ? busy4  : busy2;
  assign acc_o   = sel4 ? acc4   : acc2;
  assign valid_o = sel4 ? valid4 : valid2;
  assign done_o  = sel4 ? done4  : done2;
  assign a_o     = sel4 ? a4 : {16'h0, a2};
  assign b_o     = sel4 ? b4 : {16'h0, b2};

  systolic_feeder #(.N(2), .OP_WIDTH(W)) u_dut2 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en && !sel4), .wr_sel(wr_sel), .wr_row(wr_row[0:0]), .wr_col(wr_col[0:0]),
    .wr_data(wr_data), .start(start && !sel4),
    .busy(busy2), .acc_clear(acc2), .out_valid(valid2),
    .new_a_column(a2), .new_b_row(b2), .done(done2)
  );

  systolic_feeder #(.N(4), .OP_WIDTH(W)) u_dut4 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en && sel4), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .start(start && sel4),
    .busy(busy4), .acc_clear(acc4), .out_valid(valid4),
    .new_a_column(a4), .new_b_row(b4), .done(done4)
  );

  // Beat k from the definition: A lane i = A[i][k-i], B lane j = B[k-j][j].
  function automatic logic [31:0] exp_bus(input int k, input bit is_b);
    logic [31:0] r;
    r = '0;
    for (int ln = 0; ln < cur_n; ln++) begin
      int d;
      d = k - ln;
      if (d >= 0 && d < cur_n) r[ln*8 +: 8] = is_b ? 8'(mb[d][ln]) : 8'(ma[ln][d]);
    end
    return r;
  endfunction

  // Systolic accumulation: PE(i,j) multiplies A lane i delayed j by B lane j delayed i.
  function automatic int mac_of(input int i, input int j);
    int acc;
    logic [31:0] va, vb;
    acc = 0;
    for (int t = 0; t < aq.size() + 2 * cur_n; t++) begin
      int ta, tb;
      ta = t - j;
      tb = t - i;
      if (ta >= 0 && ta < aq.size() && tb >= 0 && tb < bq.size()) begin
        va = aq[ta];
        vb = bq[tb];
        acc += int'(va[i*8 +: 8]) * int'(vb[j*8 +: 8]);
      end
    end
    return acc;
  endfunction

  task automatic write_elem(input bit sel, input int r, input int c, input int v);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = 8'(v);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_model();
    for (int r = 0; r < cur_n; r++)
      for (int c = 0; c < cur_n; c++) begin
        write_elem(1'b0, r, c, ma[r][c]);
        write_elem(1'b1, r, c, mb[r][c]);
      end
  endtask

  // One full run; disturb 1 = start + A[0][0]=99 write during beat 1,
  // disturb 2 = A[1][1]=0xFF written in the start cycle.
  task automatic run(input int disturb);
    int len;
    len = 3 * cur_n - 2;
    aq.delete(); bq.delete();
    @(negedge clk);
    start = 1'b1;
    if (disturb == 2) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_col = 2'd1; wr_data = 8'hFF;
      ma[1][1] = 255;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    n_checks++;
    if ({acc_o, busy_o, valid_o, done_o} !== 4'b1100) begin
      n_fail++;
      $display("FAIL clear_cycle n=%0d {acc,busy,valid,done}=%b expected 1100", cur_n,
               {acc_o, busy_o, valid_o, done_o});
    end
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      n_checks++;
      if ({acc_o, busy_o, valid_o, done_o} !== 4'b0110) begin
        n_fail++;
        $display("FAIL beat_ctrl n=%0d k=%0d {acc,busy,valid,done}=%b expected 0110", cur_n, k,
                 {acc_o, busy_o, valid_o, done_o});
      end
      n_checks++;
      if (a_o !== exp_bus(k, 1'b0)) begin
        n_fail++;
        $display("FAIL beat_a n=%0d k=%0d got %h expected %h", cur_n, k, a_o, exp_bus(k, 1'b0));
      end
      n_checks++;
      if (b_o !== exp_bus(k, 1'b1)) begin
        n_fail++;
        $display("FAIL beat_b n=%0d k=%0d got %h expected %h", cur_n, k, b_o, exp_bus(k, 1'b1));
      end
      aq.push_back(a_o);
      bq.push_back(b_o);
      if (disturb == 1 && k == 1) begin
        start = 1'b1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd99;
      end
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    n_checks++;
    if ({acc_o, busy_o, valid_o, done_o, a_o, b_o} !== {4'b0101, 64'h0}) begin
      n_fail++;
      $display("FAIL done_cycle n=%0d {acc,busy,valid,done}=%b a=%h b=%h expected 0101 and zero buses",
               cur_n, {acc_o, busy_o, valid_o, done_o}, a_o, b_o);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({acc_o, busy_o, valid_o, done_o, a_o, b_o} !== 68'h0) begin
        n_fail++;
        $display("FAIL post_idle n=%0d cyc=%0d {acc,busy,valid,done}=%b a=%h b=%h expected all zero",
                 cur_n, c, {acc_o, busy_o, valid_o, done_o}, a_o, b_o);
      end
    end
  endtask

  task automatic set_2x2_example();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy2, acc2, valid2, done2, a2, b2, busy4, acc4, valid4, done4, a4, b4} !== 104'h0) begin
      n_fail++;
      $display("FAIL reset_state n2={%b%b%b%b a=%h b=%h} n4={%b%b%b%b a=%h b=%h} expected all zero",
               busy2, acc2, valid2, done2, a2, b2, busy4, acc4, valid4, done4, a4, b4);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic_2x2();
    logic [15:0] ea [4];
    logic [15:0] eb [4];
    logic [31:0] v;
    ea = '{16'h0001, 16'h0302, 16'h0400, 16'h0000};
    eb = '{16'h0005, 16'h0607, 16'h0800, 16'h0000};
    cur_n = 2;
    set_2x2_example();
    load_model();
    run(0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      v = aq[k];
      if (v[15:0] !== ea[k]) begin
        n_fail++;
        $display("FAIL table_a k=%0d got %h expected %h", k, v[15:0], ea[k]);
      end
      n_checks++;
      v = bq[k];
      if (v[15:0] !== eb[k]) begin
        n_fail++;
        $display("FAIL table_b k=%0d got %h expected %h", k, v[15:0], eb[k]);
      end
    end
  endtask

  task automatic test_mac_2x2();
    int ce [2][2];
    ce = '{'{19, 22}, '{43, 50}};
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (mac_of(i, j) !== ce[i][j]) begin
          n_fail++;
          $display("FAIL mac_2x2 C[%0d][%0d] got %0d expected %0d", i, j, mac_of(i, j), ce[i][j]);
        end
      end
  endtask

  task automatic test_busy_ignores();
    cur_n = 2;
    run(1);
    run(0);
  endtask

  task automatic test_reset_mid_run();
    cur_n = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (a_o !== exp_bus(1, 1'b0) || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_abort_beat1 a=%h valid=%b expected a=%h valid=1", a_o, valid_o, exp_bus(1, 1'b0));
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, acc_o, valid_o, done_o, a_o, b_o} !== 68'h0) begin
      n_fail++;
      $display("FAIL abort_async {busy,acc,valid,done}=%b a=%h b=%h expected all zero",
               {busy_o, acc_o, valid_o, done_o}, a_o, b_o);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy_o, done_o, valid_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_no_done cyc=%0d {busy,done,valid}=%b expected 000", c, {busy_o, done_o, valid_o});
      end
    end
    run(0);
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] v;
    cur_n = 2;
    run(2);
    v = aq[2];
    n_checks++;
    if (v[15:8] !== 8'hFF) begin
      n_fail++;
      $display("FAIL same_cycle_write beat2 lane1 got %h expected ff", v[15:8]);
    end
  endtask

  task automatic test_random_4x4();
    cur_n = 4;
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          ma[r][c] = int'($urandom_range(0, 255));
          mb[r][c] = int'($urandom_range(0, 255));
        end
      load_model();
      run(0);
      n_checks++;
      if (aq.size() != 10) begin
        n_fail++;
        $display("FAIL rand_len it=%0d got %0d beats expected 10", it, aq.size());
      end
      for (int k = 7; k < 10 && k < aq.size(); k++) begin
        n_checks++;
        if ({aq[k], bq[k]} !== 64'h0) begin
          n_fail++;
          $display("FAIL rand_flush it=%0d k=%0d a=%h b=%h expected 0", it, k, aq[k], bq[k]);
        end
      end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          int ref_c;
          ref_c = 0;
          for (int m = 0; m < 4; m++) ref_c += ma[i][m] * mb[m][j];
          n_checks++;
          if (mac_of(i, j) !== ref_c) begin
            n_fail++;
            $display("FAIL rand_mac it=%0d C[%0d][%0d] got %0d expected %0d", it, i, j, mac_of(i, j), ref_c);
          end
        end
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;
    cur_n = 2;
    test_reset();
    test_basic_2x2();
    test_mac_2x2();
    test_busy_ignores();
    test_reset_mid_run();
    test_same_cycle_write();
    test_random_4x4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Source side of the systolic MAC array's operand interface: buffers one NxN A matrix and one NxN B matrix, then drives the skewed per-cycle `new_a_column` / `new_b_row` streams the array shifts in.
- Pads the skew with zeros and appends a zero flush, so every MAC accumulates exactly A·B.
- Pulses an accumulator-clear before streaming and signals completion.
- Sits between the host/load path and the MAC array manager.

Parameters:
- N, 16, array dimension (matrices are NxN); N >= 2.
- OP_WIDTH, 8, operand width in bits.
- IDX_W, $clog2(N), row/column index width (derived).
- CNT_W, $clog2(3*N), stream counter width (derived).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write one buffer element this cycle.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_row  in  IDX_W  element row.
- wr_col  in  IDX_W  element column.
- wr_data  in  OP_WIDTH  element value.
- start  in  1  begin a streaming run.
- busy  out  1  run in progress (CLEAR, STREAM, DONE).
- acc_clear  out  1  one-cycle clear pulse to MAC accumulators.
- out_valid  out  1  stream beat valid.
- new_a_column  out  N*OP_WIDTH  A lane i at bits [i*OP_WIDTH +: OP_WIDTH].
- new_b_row  out  N*OP_WIDTH  B lane j at bits [j*OP_WIDTH +: OP_WIDTH].
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE, counter = 0.
  - busy, acc_clear, out_valid, done = 0; both stream buses = 0.
  - Buffer contents are not reset and are undefined until written.
- All outputs are registered.
- FSM states: IDLE, CLEAR, STREAM, DONE.
  - IDLE --start--> CLEAR.
  - CLEAR --> STREAM, lasting exactly one cycle.
  - STREAM stays while counter k < 3N-3; at k = 3N-3 --> DONE.
  - DONE --> IDLE, lasting exactly one cycle.
- Timing, with start sampled high at edge E0:
  - acc_clear = 1 for the cycle after E0.
  - out_valid = 1 for the next 3N-2 consecutive cycles.
  - done = 1 for the single cycle after the last beat.
  - busy = 1 from the acc_clear cycle through the done cycle inclusive.
- Beat k (k = 0..3N-3):
  - A lane i = A[i][k-i] if 0 <= k-i < N, else 0.
  - B lane j = B[k-j][j] if 0 <= k-j < N, else 0.
  - Beats 2N-1..3N-3 are all-zero flush beats.
- Stream buses are 0 whenever out_valid = 0.
- start is ignored unless in IDLE; it is not queued.
- Writes:
  - wr_en is honoured only in IDLE; it is ignored while busy.
  - A write in the same cycle as start is accepted and is visible to the run that start begins.
- Reset asserted mid-run aborts immediately to the reset state; no done pulse is produced.
- No arithmetic is performed; operands pass through unmodified (no sign handling).

Decomposition:
- Shared package holds:
  - state enum {IDLE, CLEAR, STREAM, DONE};
  - function stream_len(N) = 3N-2;
  - lane pack/unpack helper for the `[i*OP_WIDTH +: OP_WIDTH]` layout, shared with the array manager.
- One sub-module, operand_bank:
  - NxN OP_WIDTH register file with one write port;
  - N parallel skewed read ports taking (k, lane, row-major/col-major mode);
  - returns 0 when out of range.
- Instantiated twice: A in row mode, B in column mode.

Test Plan (N=2, OP_WIDTH=8 unless noted):
- Load A=[[1,2],[3,4]], B=[[5,6],[7,8]], then start -> acc_clear for 1 cycle, then 4 beats:
  - a lanes (lane0,lane1) = (1,0),(2,3),(0,4),(0,0);
  - b lanes = (5,0),(7,6),(0,8),(0,0);
  - then done = 1 for 1 cycle and busy drops the cycle after.
- Same load, feeder wired into the MAC array manager -> accumulators read C=[[19,22],[43,50]].
- start pulsed during STREAM, and wr_en writing A[0][0]=99 during STREAM -> beat sequence unchanged; a second run still shows A[0][0]=1.
- Assert reset at beat k=1 -> all outputs 0 asynchronously, no done pulse; a subsequent start yields a full, correct 4-beat run.
- Write A[1][1]=0xFF in the same cycle as start -> beat 2 a lane1 = 0xFF.
- N=4 with random matrices -> out_valid high exactly 10 cycles; every lane matches the skew formula; beats 7..9 are all zero.
